// File: rtl/asm_pkg.sv
// asm_pkg: shared constants, mode/state enums and character helpers for the
//    line assembler (asm_encoder, asm_lookup).
package asm_pkg;
   localparam logic [7:0] LF_CHAR    = 8'h0A;
   localparam logic [7:0] SPACE_CHAR = 8'h20;
   typedef enum logic [3:0] {
      MODE_NONE, IMM, ZP, ABS, IZX, IZY, ZPX, ABY, ABX, IZP
   } mode_e;
   localparam logic [2:0] AAA_ORA = 3'd0;
   localparam logic [2:0] AAA_AND = 3'd1;
   localparam logic [2:0] AAA_EOR = 3'd2;
   localparam logic [2:0] AAA_ADC = 3'd3;
   localparam logic [2:0] AAA_STA = 3'd4;
   localparam logic [2:0] AAA_LDA = 3'd5;
   localparam logic [2:0] AAA_CMP = 3'd6;
   localparam logic [2:0] AAA_SBC = 3'd7;
   typedef enum logic [2:0] {C1, C2, C3, MODE, LOOKUP, EMIT, SKIP} state_e;
   // Mnemonic letters: 'A'..'Z' and '_'
   function automatic logic is_letter(input logic [7:0] c);
      return (c >= 8'h41 && c <= 8'h5A) || c == 8'h5F;
   endfunction
   // MODE_NONE means "not a mode character"
   function automatic mode_e char_to_mode(input logic [7:0] c);
      return c == 8'h23 ? IMM :
             c == 8'h5A ? ZP  :
             c == 8'h41 ? ABS :
             c == 8'h49 ? IZX :
             c == 8'h59 ? IZY :
             c == 8'h78 ? ZPX :
             c == 8'h79 ? ABY :
             c == 8'h58 ? ABX :
             c == 8'h50 ? IZP : MODE_NONE;
   endfunction
endpackage

// File: rtl/asm_lookup.sv
// asm_lookup: combinational {mnemonic, mode} -> {opcode, hit} table.
//    i_mnem   [23:0] three ASCII chars, first char in the top byte
//    i_mode          addressing mode (MODE_NONE = implied)
//    o_opcode [7:0]  encoded opcode (valid when o_hit)
//    o_hit           pair names a legal encoding
//    Macro ASM_THREAD_OPS_EN adds the thread-op implied mnemonics.
module asm_lookup
   import asm_pkg::*;
(
   input  logic [23:0] i_mnem,
   input  mode_e       i_mode,
   output logic [7:0]  o_opcode,
   output logic        o_hit
);
   logic       w_alu;
   logic [2:0] w_aaa;
   logic [2:0] w_bbb;
   logic       w_imp_hit;
   logic [7:0] w_imp;
   always_comb begin
      w_alu = 1'b1;
      w_aaa = AAA_ORA;
      case (i_mnem)
         "ORA":   w_aaa = AAA_ORA;
         "AND":   w_aaa = AAA_AND;
         "EOR":   w_aaa = AAA_EOR;
         "ADC":   w_aaa = AAA_ADC;
         "STA":   w_aaa = AAA_STA;
         "LDA":   w_aaa = AAA_LDA;
         "CMP":   w_aaa = AAA_CMP;
         "SBC":   w_aaa = AAA_SBC;
         default: w_alu = 1'b0;
      endcase
   end
   always_comb
      w_bbb = i_mode == IMM ? 3'b010 :
              i_mode == ZP  ? 3'b001 :
              i_mode == ABS ? 3'b011 :
              i_mode == IZX ? 3'b000 :
              i_mode == IZY ? 3'b100 :
              i_mode == ZPX ? 3'b101 :
              i_mode == ABY ? 3'b110 : 3'b111;
   always_comb begin
      w_imp_hit = 1'b1;
      w_imp     = 8'h00;
      case (i_mnem)
         "BRK": w_imp = 8'h00;
         "PHP": w_imp = 8'h08;
         "CLC": w_imp = 8'h18;
         "INA": w_imp = 8'h1A;
         "DEA": w_imp = 8'h3A;
         "PHY": w_imp = 8'h5A;
         "PLY": w_imp = 8'h7A;
         "PHX": w_imp = 8'hDA;
         "PLX": w_imp = 8'hFA;
         "TXA": w_imp = 8'h8A;
         "TYA": w_imp = 8'h98;
         "TXS": w_imp = 8'h9A;
         "TAY": w_imp = 8'hA8;
         "TAX": w_imp = 8'hAA;
         "TSX": w_imp = 8'hBA;
         "CLV": w_imp = 8'hB8;
         "DEY": w_imp = 8'h88;
         "INY": w_imp = 8'hC8;
         "DEX": w_imp = 8'hCA;
         "INX": w_imp = 8'hE8;
         "NOP": w_imp = 8'hEA;
         "SED": w_imp = 8'hF8;
         "SEI": w_imp = 8'h78;
         "CLI": w_imp = 8'h58;
         "CLD": w_imp = 8'hD8;
         "SEC": w_imp = 8'h38;
         "RTI": w_imp = 8'h40;
         "RTS": w_imp = 8'h60;
         "PHA": w_imp = 8'h48;
         "PLA": w_imp = 8'h68;
         "PLP": w_imp = 8'h28;
         "STP": w_imp = 8'hDB;
`ifdef ASM_THREAD_OPS_EN
         "CPU": w_imp = 8'h0F;
         "A24": w_imp = 8'h1F;
         "THR": w_imp = 8'h03;
         "THW": w_imp = 8'h13;
         "THY": w_imp = 8'h23;
         "THI": w_imp = 8'h33;
         "TTA": w_imp = 8'h43;
         "TAT": w_imp = 8'h53;
         "TTS": w_imp = 8'h63;
         "TST": w_imp = 8'h73;
         "_T_": w_imp = 8'hF3;
`endif
         default: w_imp_hit = 1'b0;
      endcase
   end
   // ALU group needs a mode, and there is no store-immediate
   assign o_hit    = w_alu ? (i_mode != MODE_NONE && !(w_aaa == AAA_STA && i_mode == IMM))
                           : (w_imp_hit && i_mode == MODE_NONE);
   assign o_opcode = w_alu ? (i_mode == IZP ? {w_aaa, 5'b10010} : {w_aaa, w_bbb, 2'b01})
                           : w_imp;
endmodule

// File: rtl/asm_encoder.sv
// asm_encoder: ASCII line assembler, one "MNM[mode]\n" line -> one opcode byte.
//    clk, reset            clock, synchronous active-high reset
//    in_char/in_valid/in_ready     character stream (spaces ignored)
//    out_opcode/out_valid/out_ready opcode stream
//    err                   one-cycle pulse when a line is rejected
//    mnem [23:0]           mnemonic of the current/last line
//    Macro ASM_THREAD_OPS_EN (in asm_lookup) enables the thread-op mnemonics.
module asm_encoder
   import asm_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  in_char,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [7:0]  out_opcode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        err,
   output logic [23:0] mnem
);
   state_e      r_state;
   state_e      w_next;
   logic [23:0] r_mnem;
   mode_e       r_mode;
   logic        r_bad;
   logic [7:0]  r_opcode;
   logic        r_err;
   logic        w_acc;
   logic        w_lf;
   logic        w_letter;
   mode_e       w_mode;
   logic        w_modec;
   logic [7:0]  w_opcode;
   logic        w_hit;
   logic        w_ok;
   logic        w_done;
   asm_lookup u_lookup (
      .i_mnem   (r_mnem),
      .i_mode   (r_mode),
      .o_opcode (w_opcode),
      .o_hit    (w_hit)
   );
   assign w_acc    = in_valid && in_ready && in_char != SPACE_CHAR;
   assign w_lf     = in_char == LF_CHAR;
   assign w_letter = is_letter(in_char);
   assign w_mode   = char_to_mode(in_char);
   assign w_modec  = w_mode != MODE_NONE;
   // Malformed lines are funnelled through LOOKUP with r_bad set so every
   // rejection shares the same LF-to-err latency as a table miss.
   assign w_ok     = w_hit && !r_bad;
   assign w_done   = (r_state == LOOKUP && !w_ok) || (r_state == EMIT && out_ready);
   always_ff @(posedge clk)
      if (reset) r_state <= C1;
      else       r_state <= w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         C1:     if (w_acc) w_next = w_lf ? C1 : w_letter ? C2 : SKIP;
         C2:     if (w_acc) w_next = w_lf ? LOOKUP : w_letter ? C3 : SKIP;
         C3:     if (w_acc) w_next = w_lf ? LOOKUP : w_letter ? MODE : SKIP;
         MODE:   if (w_acc) w_next = w_lf ? LOOKUP : w_modec ? MODE : SKIP;
         SKIP:   if (w_acc) w_next = w_lf ? LOOKUP : SKIP;
         LOOKUP: w_next = w_ok ? EMIT : C1;
         EMIT:   w_next = out_ready ? C1 : EMIT;
         default: w_next = C1;
      endcase
   end
   always_comb begin
      in_ready  = !(r_state inside {LOOKUP, EMIT});
      out_valid = r_state == EMIT;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mnem   <= '0;
         r_mode   <= MODE_NONE;
         r_bad    <= 1'b0;
         r_opcode <= '0;
         r_err    <= 1'b0;
      end else begin
         r_err <= r_state == LOOKUP && !w_ok;
         if (r_state == LOOKUP && w_ok) r_opcode <= w_opcode;
         if (w_done) begin
            r_mnem <= '0;
            r_mode <= MODE_NONE;
            r_bad  <= 1'b0;
         end else begin
            if (w_acc && w_letter && r_state inside {C1, C2, C3}) r_mnem <= {r_mnem[15:0], in_char};
            if (w_acc && r_state == MODE && w_modec) begin
               if (r_mode != MODE_NONE) r_bad <= 1'b1;
               else                     r_mode <= w_mode;
            end
            if (w_acc && (w_next == SKIP || (w_lf && r_state inside {C2, C3}))) r_bad <= 1'b1;
         end
      end
   end
   assign out_opcode = r_opcode;
   assign err        = r_err;
   assign mnem       = r_mnem;
endmodule

// File: tb/tb_asm_encoder.sv
// tb_asm_encoder: directed self-checking bench for asm_encoder.
module tb_asm_encoder;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  in_char = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  out_opcode;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        err;
   logic [23:0] mnem;
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   asm_encoder dut (
      .clk        (clk),
      .reset      (reset),
      .in_char    (in_char),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_opcode (out_opcode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .err        (err),
      .mnem       (mnem)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic send_char(input logic [7:0] c);
      int n;
      n = 0;
      in_char  = c;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
   endtask
   task automatic send_line(input string s);
      for (int i = 0; i < s.len(); i++) send_char(s[i]);
      send_char(8'h0A);
   endtask
   task automatic expect_op(input string tag, input logic [7:0] op);
      chk({tag, "_n1_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_n1_err"}, {31'd0, err}, 32'd0);
      step();
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_opcode"}, {24'd0, out_opcode}, {24'd0, op});
      chk({tag, "_err"}, {31'd0, err}, 32'd0);
      step();
      chk({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
   endtask
   task automatic expect_err(input string tag);
      chk({tag, "_n1_err"}, {31'd0, err}, 32'd0);
      step();
      chk({tag, "_err"}, {31'd0, err}, 32'd1);
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
      step();
      chk({tag, "_err_pulse"}, {31'd0, err}, 32'd0);
      chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      step();
      step();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_opcode", {24'd0, out_opcode}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_mnem", {8'd0, mnem}, 32'd0);
      reset = 1'b0;
      step();
      send_line("LDA#");
      chk("lda_n1_valid", {31'd0, out_valid}, 32'd0);
      step();
      chk("lda_valid", {31'd0, out_valid}, 32'd1);
      chk("lda_opcode", {24'd0, out_opcode}, 32'hA9);
      chk("lda_mnem", {8'd0, mnem}, 32'h4C4441);
      chk("lda_err", {31'd0, err}, 32'd0);
      step();
      chk("lda_drop", {31'd0, out_valid}, 32'd0);
      chk("lda_mnem_clr", {8'd0, mnem}, 32'd0);
      send_line("NOP");
      expect_op("nop", 8'hEA);
      send_line("S T A X");
      expect_op("stax", 8'h9D);
      send_line("STA#");
      expect_err("sta_imm");
      send_line("RTS");
      expect_op("rts", 8'h60);
      out_ready = 1'b0;
      send_line("LDA#");
      chk("stall_n1_ready", {31'd0, in_ready}, 32'd0);
      step();
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", {31'd0, out_valid}, 32'd1);
         chk("stall_opcode", {24'd0, out_opcode}, 32'hA9);
         chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
         step();
      end
      out_ready = 1'b1;
      chk("stall_last_valid", {31'd0, out_valid}, 32'd1);
      step();
      chk("stall_done_valid", {31'd0, out_valid}, 32'd0);
      chk("stall_done_ready", {31'd0, in_ready}, 32'd1);
      send_line("THR");
`ifdef ASM_THREAD_OPS_EN
      expect_op("thr", 8'h03);
`else
      expect_err("thr");
`endif
      send_line("LD");
      expect_err("ld_short");
      send_line("LDAZZ");
      expect_err("lda_zz");
      chk("lda_zz_quiet", {31'd0, err}, 32'd0);
      send_line("LDAB");
      expect_err("lda_badmode");
      send_line("LDA");
      expect_err("lda_nomode");
      send_line("LDAx");
      expect_op("lda_zpx", 8'hB5);
      send_line("CMPP");
      expect_op("cmp_izp", 8'hD2);
      send_line("SBCy");
      expect_op("sbc_aby", 8'hF9);
      send_line("BRK");
      expect_op("brk", 8'h00);
      send_line("NOP#");
      expect_err("nop_imm");
      send_char(8'h0A);
      for (int i = 0; i < 3; i++) begin
         chk("empty_err", {31'd0, err}, 32'd0);
         chk("empty_valid", {31'd0, out_valid}, 32'd0);
         step();
      end
      send_char("A");
      send_char("D");
      send_char("C");
      chk("adc_mnem", {8'd0, mnem}, 32'h414443);
      reset = 1'b1;
      step();
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_err", {31'd0, err}, 32'd0);
      chk("mid_rst_mnem", {8'd0, mnem}, 32'd0);
      reset = 1'b0;
      step();
      chk("mid_rst_err2", {31'd0, err}, 32'd0);
      send_line("INX");
      expect_op("inx", 8'hE8);
      out_ready = 1'b0;
      send_line("NOP");
      step();
      chk("emit_rst_pre", {31'd0, out_valid}, 32'd1);
      reset = 1'b1;
      step();
      chk("emit_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("emit_rst_opcode", {24'd0, out_opcode}, 32'd0);
      reset = 1'b0;
      out_ready = 1'b1;
      step();
      chk("emit_rst_err", {31'd0, err}, 32'd0);
      chk("emit_rst_ready", {31'd0, in_ready}, 32'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
